// File: rtl/motor_pwm_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | motor_pwm_pkg : register map, control bit positions and reset defaults       |
// | Revision      : 1.0                                                           |
// +-----------------------------------------------------------------------------+
package motor_pwm_pkg;

  localparam int CNT_W = 16;
  localparam int LIM_W = 4;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIOD  = 3'd2;
  localparam logic [2:0] ADDR_DUTY0   = 3'd3;
  localparam logic [2:0] ADDR_DUTY1   = 3'd4;
  localparam logic [2:0] ADDR_DIR     = 3'd5;
  localparam logic [2:0] ADDR_CNT     = 3'd6;

  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int CTRL_SAFETY_EN_BIT = 2;
  localparam int CTRL_LIM_LSB       = 4;

  localparam logic [CNT_W-1:0] PERIOD_RST_DEF   = 16'd999;
  localparam logic [LIM_W-1:0] TICK_LIM_RST_DEF = 4'd4;

  typedef struct packed {
    logic [LIM_W-1:0] lim;
    logic             safety_en;
    logic             irq_en;
    logic             enable;
  } ctrl_t;

  function automatic logic [15:0] pack_ctrl(input ctrl_t c);
    return {8'h00, c.lim, 1'b0, c.safety_en, c.irq_en, c.enable};
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_pwm_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | motor_pwm_if : Avalon-MM slave bus (16-bit data, 3-bit word address)         |
// | Revision     : 1.0                                                            |
// +-----------------------------------------------------------------------------+
interface motor_pwm_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pwm_channel : one PWM output with shadow/active duty and registered compare  |
// | Revision    : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module pwm_channel
  import motor_pwm_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             wr_duty,
  input  wire logic [CNT_W-1:0] wdata,
  input  wire logic [CNT_W-1:0] cnt,
  input  wire logic             wrap,
  input  wire logic             enable,
  input  wire logic             block,
  output logic      [CNT_W-1:0] duty_shadow,
  output logic                  pwm
);

  logic [CNT_W-1:0] duty_sh_q,  duty_sh_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             pwm_q,      pwm_d;

  always_comb begin
    duty_sh_d  = duty_sh_q;
    duty_act_d = duty_act_q;
    if (wr_duty) begin
      duty_sh_d = wdata;
    end
    // Active copy samples the pre-write shadow, so a write on the wrap clock waits a period.
    if (!enable || wrap) begin
      duty_act_d = duty_sh_q;
    end
    pwm_d = enable & ~block & (cnt < duty_act_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign duty_shadow = duty_sh_q;
  assign pwm         = pwm_q;

endmodule
`default_nettype wire

// File: rtl/motor_pwm_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | motor_pwm_ctrl : two-channel motor PWM with direction bits and a timer-tick  |
// |                  heartbeat trip (heartbeat built when MOTOR_PWM_SAFETY_EN)   |
// | Revision       : 1.0                                                          |
// +-----------------------------------------------------------------------------+
module motor_pwm_ctrl
  import motor_pwm_pkg::*;
#(
  parameter logic [CNT_W-1:0] PERIOD_RST   = PERIOD_RST_DEF,
  parameter logic [LIM_W-1:0] TICK_LIM_RST = TICK_LIM_RST_DEF
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  motor_pwm_if.slave      bus,
  input  wire logic       tick_in,
  output logic      [1:0] pwm_out,
  output logic      [1:0] dir_out,
  output logic            irq
);

  logic             wr;
  logic             wr_status, wr_control, wr_period, wr_dir;
  logic [1:0]       wr_duty;
  logic             wrap;
  logic             tripped;

  ctrl_t            ctrl_q,       ctrl_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             wrap_flag_q,  wrap_flag_d;
  logic [1:0]       dir_q,        dir_d;
  logic [15:0]      readdata_q,   readdata_d;
  logic [CNT_W-1:0] duty_sh [2];

  always_comb begin
    wr         = bus.chipselect & ~bus.write_n;
    wr_status  = wr & (bus.address == ADDR_STATUS);
    wr_control = wr & (bus.address == ADDR_CONTROL);
    wr_period  = wr & (bus.address == ADDR_PERIOD);
    wr_duty[0] = wr & (bus.address == ADDR_DUTY0);
    wr_duty[1] = wr & (bus.address == ADDR_DUTY1);
    wr_dir     = wr & (bus.address == ADDR_DIR);
    wrap       = ctrl_q.enable & (cnt_q == period_act_q);
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    period_d     = period_q;
    period_act_d = period_act_q;
    cnt_d        = cnt_q;
    wrap_flag_d  = wrap_flag_q;
    dir_d        = dir_q;

    if (wr_control) begin
      ctrl_d.enable    = bus.writedata[CTRL_EN_BIT];
      ctrl_d.irq_en    = bus.writedata[CTRL_IRQ_EN_BIT];
      ctrl_d.safety_en = bus.writedata[CTRL_SAFETY_EN_BIT];
      ctrl_d.lim       = bus.writedata[CTRL_LIM_LSB +: LIM_W];
    end
    if (wr_period) begin
      period_d = bus.writedata;
    end
    if (wr_dir) begin
      dir_d = bus.writedata[1:0];
    end

    if (!ctrl_q.enable) begin
      cnt_d        = '0;
      period_act_d = period_q;
    end else if (wrap) begin
      cnt_d        = '0;
      period_act_d = period_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    // A wrap on the same clock as a status write keeps the flag set.
    if (wrap) begin
      wrap_flag_d = 1'b1;
    end else if (wr_status) begin
      wrap_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q       <= '{lim: TICK_LIM_RST, safety_en: 1'b0, irq_en: 1'b0, enable: 1'b0};
      period_q     <= PERIOD_RST;
      period_act_q <= PERIOD_RST;
      cnt_q        <= '0;
      wrap_flag_q  <= 1'b0;
      dir_q        <= 2'b00;
    end else begin
      ctrl_q       <= ctrl_d;
      period_q     <= period_d;
      period_act_q <= period_act_d;
      cnt_q        <= cnt_d;
      wrap_flag_q  <= wrap_flag_d;
      dir_q        <= dir_d;
    end
  end

`ifdef MOTOR_PWM_SAFETY_EN
  logic             tick_q,    tick_d;
  logic [LIM_W-1:0] hb_cnt_q,  hb_cnt_d;
  logic             tripped_q, tripped_d;
  logic             tick_edge;
  logic             trip_cond;

  always_comb begin
    tick_d    = tick_in;
    tick_edge = tick_in & ~tick_q;
    hb_cnt_d  = hb_cnt_q;
    tripped_d = tripped_q;
    trip_cond = ctrl_q.safety_en & (ctrl_q.lim != '0) & (hb_cnt_q >= ctrl_q.lim);

    // A duty refresh is the heartbeat; it beats a tick edge on the same clock.
    if (wr_duty[0] || wr_duty[1]) begin
      hb_cnt_d = '0;
    end else if (tick_edge && (hb_cnt_q != '1)) begin
      hb_cnt_d = hb_cnt_q + 4'd1;
    end

    if (trip_cond) begin
      tripped_d = 1'b1;
    end else if (wr_status) begin
      tripped_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q    <= 1'b0;
      hb_cnt_q  <= '0;
      tripped_q <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      hb_cnt_q  <= hb_cnt_d;
      tripped_q <= tripped_d;
    end
  end

  assign tripped = tripped_q;
`else
  logic unused_tick_in;
  assign unused_tick_in = tick_in;
  assign tripped        = 1'b0;
`endif

  generate
    for (genvar i = 0; i < 2; i++) begin : g_ch
      pwm_channel u_ch (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_duty     (wr_duty[i]),
        .wdata       (bus.writedata),
        .cnt         (cnt_q),
        .wrap        (wrap),
        .enable      (ctrl_q.enable),
        .block       (tripped),
        .duty_shadow (duty_sh[i]),
        .pwm         (pwm_out[i])
      );
    end
  endgenerate

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_STATUS:  readdata_d = {14'd0, wrap_flag_q, tripped};
      ADDR_CONTROL: readdata_d = pack_ctrl(ctrl_q);
      ADDR_PERIOD:  readdata_d = period_q;
      ADDR_DUTY0:   readdata_d = duty_sh[0];
      ADDR_DUTY1:   readdata_d = duty_sh[1];
      ADDR_DIR:     readdata_d = {14'd0, dir_q};
      ADDR_CNT:     readdata_d = cnt_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign dir_out      = dir_q;
  assign irq          = wrap_flag_q & ctrl_q.irq_en;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_motor_pwm_ctrl : directed, table-driven bench for motor_pwm_ctrl          |
// | Revision          : 1.0                                                       |
// +-----------------------------------------------------------------------------+
module tb_motor_pwm_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick_in;
  logic [1:0] pwm_out;
  logic [1:0] dir_out;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MOTOR_PWM_SAFETY_EN
  localparam logic EXP_TRIP = 1'b1;
`else
  localparam logic EXP_TRIP = 1'b0;
`endif

  motor_pwm_if bus ();

  motor_pwm_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .tick_in (tick_in),
    .pwm_out (pwm_out),
    .dir_out (dir_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t rst_tbl [8];
  vec_t rw_tbl  [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus tasks are entered at a falling edge and leave one falling edge later.
  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic count_hi(input int n, output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < n; i++) begin
      h0 += 32'(pwm_out[0]);
      h1 += 32'(pwm_out[1]);
      @(negedge clk);
    end
  endtask

  task automatic wait_rise0();
    logic prev;
    logic seen;
    seen = 1'b0;
    prev = pwm_out[0];
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pwm_out[0] && !prev) seen = 1'b1;
      prev = pwm_out[0];
    end
    check("pwm0_rise_timeout", 16'(seen), 16'd1);
  endtask

  task automatic check_defaults(input string tag);
    logic [15:0] v;
    for (int i = 0; i < 8; i++) begin
      bus_rd(rst_tbl[i].addr, v);
      check($sformatf("%s_reg%0d", tag, i), v, rst_tbl[i].exp);
    end
    check({tag, "_pwm"}, 16'(pwm_out), 16'd0);
    check({tag, "_irq"}, 16'(irq), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int h0, h1;

    rst_tbl[0] = '{3'd0, 16'h0000, 16'h0000};
    rst_tbl[1] = '{3'd1, 16'h0000, 16'h0040};
    rst_tbl[2] = '{3'd2, 16'h0000, 16'd999};
    rst_tbl[3] = '{3'd3, 16'h0000, 16'h0000};
    rst_tbl[4] = '{3'd4, 16'h0000, 16'h0000};
    rst_tbl[5] = '{3'd5, 16'h0000, 16'h0000};
    rst_tbl[6] = '{3'd6, 16'h0000, 16'h0000};
    rst_tbl[7] = '{3'd7, 16'h0000, 16'h0000};

    rw_tbl[0] = '{3'd1, 16'hFFF6, 16'h00F6};
    rw_tbl[1] = '{3'd2, 16'h1234, 16'h1234};
    rw_tbl[2] = '{3'd3, 16'hABCD, 16'hABCD};
    rw_tbl[3] = '{3'd4, 16'h0005, 16'h0005};
    rw_tbl[4] = '{3'd5, 16'hFFFF, 16'h0003};
    rw_tbl[5] = '{3'd6, 16'h7777, 16'h0000};
    rw_tbl[6] = '{3'd7, 16'hFFFF, 16'h0000};
    rw_tbl[7] = '{3'd0, 16'hFFFF, 16'h0000};

    reset_n        = 1'b0;
    tick_in        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_readdata", bus.readdata, 16'h0000);
    check("rst_dir", 16'(dir_out), 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    check_defaults("reset");

    for (int i = 0; i < 8; i++) begin
      bus_wr(rw_tbl[i].addr, rw_tbl[i].wdata);
      bus_rd(rw_tbl[i].addr, v);
      check($sformatf("rw_addr%0d", rw_tbl[i].addr), v, rw_tbl[i].exp);
    end
    check("dir_out_rw", 16'(dir_out), 16'd3);

    // period 9, duty0 3, duty1 10 (> period), dir 01
    bus_wr(3'd1, 16'h0040);
    bus_wr(3'd2, 16'd9);
    bus_wr(3'd3, 16'd3);
    bus_wr(3'd4, 16'd10);
    bus_wr(3'd5, 16'h0001);
    bus_wr(3'd0, 16'h0000);
    bus_wr(3'd1, 16'h0041);
    check("dir_out_1", 16'(dir_out), 16'd1);

    wait_rise0();
    count_hi(10, h0, h1);
    check("duty3_hi", 16'(h0), 16'd3);
    check("duty_gt_period_hi", 16'(h1), 16'd10);
    check("period10_rise", 16'(pwm_out[0]), 16'd1);

    // Mid-period duty change keeps the old duty until wrap.
    bus_wr(3'd3, 16'd5);
    count_hi(9, h0, h1);
    check("old_duty_rest", 16'(h0), 16'd2);
    count_hi(10, h0, h1);
    check("new_duty5_hi", 16'(h0), 16'd5);
    repeat (8) @(negedge clk);
    bus_wr(3'd3, 16'd7);
    wait_rise0();
    count_hi(10, h0, h1);
    check("wrap_clk_write_still5", 16'(h0), 16'd5);
    count_hi(10, h0, h1);
    check("wrap_clk_write_now7", 16'(h0), 16'd7);

    // irq: clear, enable, wait for first wrap
    bus_wr(3'd0, 16'h0000);
    bus_wr(3'd1, 16'h0043);
    check("irq_after_clear", 16'(irq), 16'd0);
    for (int i = 0; i < 20 && !irq; i++) @(negedge clk);
    check("irq_rise", 16'(irq), 16'd1);
    check("irq_before_pwm_rise", 16'(pwm_out[0]), 16'd0);
    bus_rd(3'd0, v);
    check("status_wrap", v, 16'h0002);
    check("pwm_rise_after_irq", 16'(pwm_out[0]), 16'd1);
    repeat (8) @(negedge clk);
    bus_wr(3'd0, 16'h0000);
    check("irq_set_wins", 16'(irq), 16'd1);
    bus_wr(3'd0, 16'h0000);
    check("irq_cleared", 16'(irq), 16'd0);

    // Heartbeat: lim=2, safety_en=1, enable=1, irq off
    bus_wr(3'd1, 16'h0025);
    bus_wr(3'd3, 16'd7);
    tick_in = 1'b1;
    repeat (4) @(negedge clk);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    bus_rd(3'd0, v);
    check("held_tick_once", 16'(v[0]), 16'd0);
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    bus_rd(3'd0, v);
    check("tripped_after_2", 16'(v[0]), 16'(EXP_TRIP));
    count_hi(10, h0, h1);
    check("pwm0_tripped", 16'(h0), EXP_TRIP ? 16'd0 : 16'd7);
    check("pwm1_tripped", 16'(h1), EXP_TRIP ? 16'd0 : 16'd10);
    bus_wr(3'd3, 16'd7);
    bus_wr(3'd0, 16'h0000);
    repeat (2) @(negedge clk);
    count_hi(10, h0, h1);
    check("pwm0_resumed", 16'(h0), 16'd7);
    bus_rd(3'd0, v);
    check("trip_cleared", 16'(v[0]), 16'd0);

    // period 0: wrap every clock
    bus_wr(3'd1, 16'h0041);
    bus_wr(3'd2, 16'd0);
    bus_wr(3'd3, 16'd1);
    bus_wr(3'd4, 16'd0);
    repeat (25) @(negedge clk);
    count_hi(5, h0, h1);
    check("p0_duty1_hi", 16'(h0), 16'd5);
    check("p0_duty0_hi", 16'(h1), 16'd0);
    bus_rd(3'd6, v);
    check("p0_cnt", v, 16'd0);

    // Asynchronous reset mid-period
    bus_wr(3'd2, 16'd9);
    bus_wr(3'd5, 16'h0002);
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pwm", 16'(pwm_out), 16'd0);
    check("async_rst_dir", 16'(dir_out), 16'd0);
    check("async_rst_irq", 16'(irq), 16'd0);
    check("async_rst_rdata", bus.readdata, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_defaults("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
